des_rr_sched: RTL
=================

Name: des_rr_sched

Overview:
- Round-robin scheduler that shares one single-bit evaluate datapath (XOR/OR accumulator plus result register) among N requesters.
- Arbitrates requests, captures the winner's operands and sequences a fixed-length evaluation.
- Returns the result with a one-cycle valid/ack pulse tagged by requester index.
- Sits between the per-lane operand sources and the shared result consumer in the test-design netlist.

Parameters:
N, 4, number of requesters (2..8)
IDW, 2, index width, equal to clog2(N)
EVAL_CYCLES, 2, number of accumulate cycles per transaction (>=1)

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous, active-low reset
en  input  1  global enable; 0 = stall, with all state held
req  input  N  per-requester request level; the requester holds it until its ack
a  input  N  operand a, one bit per requester
b  input  N  operand b, one bit per requester
c  input  N  operand c, one bit per requester
gnt  output  N  one-hot grant, asserted in GRANT and EVAL
ack  output  N  one-hot completion pulse to the served requester
busy  output  1  high whenever state is not IDLE
f  output  1  registered result; holds until the next completion
f_valid  output  1  one-cycle pulse marking a new f
f_id  output  IDW  index of the requester that produced f

Behaviour:
- Reset (rst=0 at an edge, in any state):
  - state=IDLE, ptr=0, cnt=0, acc=0.
  - Captured operands cleared.
  - Outputs: f=0, f_id=0, gnt=0, ack=0, f_valid=0, busy=0.
  - Reset overrides en.
- Stall: with en=0 there is no state, ptr, cnt, acc, f or f_id change. ack and f_valid are forced 0. gnt and busy reflect the held state.
- FSM, evaluated only when en=1:
  - IDLE: if any req bit is set, search upward from ptr with wrap and pick the first set bit as sel, then go to GRANT. If no req bit is set, stay in IDLE.
  - GRANT (1 cycle):
    - gnt[sel]=1.
    - Capture ac=a[sel], bc=b[sel], cc=c[sel].
    - acc <= (a[sel]^b[sel]) | (c[sel]^a[sel]).
    - cnt <= 0. Next state EVAL.
  - EVAL:
    - gnt[sel]=1.
    - Each cycle: acc <= acc ^ (bc|cc) and cnt <= cnt+1.
    - When cnt == EVAL_CYCLES-1, go to DONE.
  - DONE (1 cycle):
    - f <= acc, f_id <= sel.
    - f_valid=1 and ack[sel]=1, decoded from state==DONE && en.
    - ptr <= (sel+1) mod N. Next state IDLE.
- Arithmetic:
  - cnt width is clog2(EVAL_CYCLES+1); it never exceeds EVAL_CYCLES-1.
  - Final f = init ^ ((bc|cc) if EVAL_CYCLES is odd, else 0).
- Latency:
  - A req first seen in IDLE at edge t gives GRANT at t+1, EVAL at t+2..t+1+EVAL_CYCLES, and DONE at t+2+EVAL_CYCLES.
  - Throughput is one transaction per 3+EVAL_CYCLES cycles, because IDLE always lasts at least one cycle.
- Boundary conditions:
  - req changes after GRANT are ignored and the transaction always completes; there is no abort.
  - Operand changes after GRANT are ignored because operands are captured once.
  - A req from the served requester that is still set at the IDLE following its DONE is considered only after all other set requesters (ptr has advanced).
  - ptr wraps from N-1 to 0.
  - Only one bit of gnt or ack is ever set.

Test Plan:
1. Reset: rst=0 for 2 cycles with random req/en -> gnt=0, ack=0, busy=0, f=0, f_valid=0, f_id=0. With req=0001 after release, the first grant is gnt=0001.
2. Single request (N=4, EVAL_CYCLES=2): req=0010 and a[1]=1, b[1]=0, c[1]=0 at edge t, req dropped at ack -> gnt=0010 at t+1..t+3; at t+4 f_valid=1, ack=0010, f=1, f_id=1.
3. Round-robin: req=1111 held, en=1 -> f_id sequence 0,1,2,3,0 with exactly one ack every 5 cycles and no lane starved.
4. Odd length (EVAL_CYCLES=3): a=0, b=1, c=0 on lane 2 -> init=1, then three XORs with 1 -> f=0, f_id=2, f_valid at t+5.
5. Stall: en=0 for 3 cycles mid-EVAL -> gnt stays set, busy=1, and the f_valid/ack pulse occurs exactly 3 cycles later than test 2 with the same f=1. No pulse while en=0.
6. Reset mid-operation: rst=0 during EVAL of lane 3 -> next cycle gnt=0, busy=0, f=0, no ack. With req=1001 afterward, lane 0 is granted first (ptr=0).

Source files
------------

// File: rtl/des_rr_sched_if.sv
// Requester/consumer bundle for the round-robin evaluate scheduler.
// The master side drives requests and operands; the slave side is the scheduler.
interface des_rr_sched_if #(
    parameter int N   = 4,
    parameter int IDW = 2
);
    logic           en;
    logic [N-1:0]   req;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [N-1:0]   c;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic           busy;
    logic           f;
    logic           f_valid;
    logic [IDW-1:0] f_id;

    modport master (
        output en, req, a, b, c,
        input  gnt, ack, busy, f, f_valid, f_id
    );

    modport slave (
        input  en, req, a, b, c,
        output gnt, ack, busy, f, f_valid, f_id
    );
endinterface

// File: rtl/des_rr_sched.sv
// Round-robin scheduler sharing one single-bit XOR/OR evaluate datapath among
// N requesters; results come back as a one-cycle pulse tagged with the lane.
module des_rr_sched #(
    parameter int N           = 4,
    parameter int IDW         = 2,
    parameter int EVAL_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    des_rr_sched_if.slave bus
);
    localparam int CW = $clog2(EVAL_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        EVAL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] sel_q, sel_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           acc_q, acc_d;
    logic           bc_q, bc_d;
    logic           cc_q, cc_d;
    logic           f_q, f_d;
    logic [IDW-1:0] f_id_q, f_id_d;

    logic [IDW-1:0] pick;
    logic [IDW:0]   scan;
    logic [N-1:0]   sel_oh;
    logic           acc_step;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_sel_oh
            assign sel_oh[gi] = (sel_q == IDW'(gi));
        end
    endgenerate

    // Scan offsets from far to near so the lane closest above ptr wins.
    always_comb begin
        pick = ptr_q;
        scan = '0;
        for (int i = N - 1; i >= 0; i--) begin
            scan = {1'b0, ptr_q} + (IDW + 1)'(i);
            if (scan >= (IDW + 1)'(N)) begin
                scan = scan - (IDW + 1)'(N);
            end
            if (bus.req[scan[IDW-1:0]]) begin
                pick = scan[IDW-1:0];
            end
        end
    end

    assign acc_step = acc_q ^ (bc_q | cc_q);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        bc_d    = bc_q;
        cc_d    = cc_q;
        f_d     = f_q;
        f_id_d  = f_id_q;
        if (bus.en) begin
            case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        sel_d   = pick;
                        state_d = GRANT;
                    end
                end
                GRANT: begin
                    // a only feeds the initial value, so only b and c are kept.
                    bc_d    = bus.b[sel_q];
                    cc_d    = bus.c[sel_q];
                    acc_d   = (bus.a[sel_q] ^ bus.b[sel_q]) | (bus.c[sel_q] ^ bus.a[sel_q]);
                    cnt_d   = '0;
                    state_d = EVAL;
                end
                EVAL: begin
                    acc_d = acc_step;
                    if (cnt_q == CW'(EVAL_CYCLES - 1)) begin
                        // Result lands on entry to DONE so f is valid with f_valid.
                        cnt_d   = '0;
                        f_d     = acc_step;
                        f_id_d  = sel_q;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    ptr_d   = (sel_q == IDW'(N - 1)) ? '0 : sel_q + IDW'(1);
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            bc_q    <= 1'b0;
            cc_q    <= 1'b0;
            f_q     <= 1'b0;
            f_id_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            bc_q    <= bc_d;
            cc_q    <= cc_d;
            f_q     <= f_d;
            f_id_q  <= f_id_d;
        end
    end

    assign bus.gnt     = (state_q == GRANT || state_q == EVAL) ? sel_oh : '0;
    assign bus.ack     = (state_q == DONE && bus.en) ? sel_oh : '0;
    assign bus.f_valid = (state_q == DONE) && bus.en;
    assign bus.busy    = (state_q != IDLE);
    assign bus.f       = f_q;
    assign bus.f_id    = f_id_q;
endmodule
